multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// - Main control FSM for the multicycle MIPS datapath; the driving end of the ALU's AluCtrl/Zero interface.
// - Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction.
// - Decodes Opcode/Funct and issues AluCtrl plus all datapath enables and mux selects.
// - Consumes Zero for beq and MemReady from the memory port.
// PARAMETERS
// - RESET_STATE  FETCH  state entered on reset
// PORTS
// - Clk        in   1  single clock, rising edge
// - Rst_n      in   1  asynchronous, active-low reset
// - Opcode     in   6  Instr[31:26] from the instruction register
// - Funct      in   6  Instr[5:0] from the instruction register
// - Zero       in   1  ALU zero flag
// - MemReady   in   1  memory access completes this cycle
// - PcEn       out  1  PC load = PcWrite | (Branch & Zero)
// - IorD       out  1  memory address select: 0 = PC, 1 = ALUOut
// - MemRead    out  1  memory read request
// - MemWrite   out  1  memory write request
// - IrWrite    out  1  instruction register load
// - RegDst     out  1  write register select: 0 = rt, 1 = rd
// - MemToReg   out  1  write data select: 0 = ALUOut, 1 = MDR
// - RegWrite   out  1  register file write enable
// - AluSrcA    out  1  ALU A select: 0 = PC, 1 = A
// - AluSrcB    out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
// - PcSrc      out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
// - AluCtrl    out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 110 SUB, 111 SLT
// - IllegalOp  out  1  one-cycle pulse on an undecodable instruction
// - State      out  4  current state, for debug
// BEHAVIOUR
// - Rst_n low: State = FETCH immediately.
//   - All enables/requests = 0, all selects = 0, AluCtrl = 010.
//   - Takes effect mid-instruction; no write completes.
// - Moore outputs decoded from the registered state. Only PcEn also depends on Zero.
// - FETCH:
//   - MemRead = 1, IorD = 0, AluSrcA = 0, AluSrcB = 01, AluCtrl = 010.
//   - IrWrite = PcWrite = MemReady; PcSrc = 00.
//   - Stay while MemReady = 0; go to DECODE when MemReady = 1.
// - DECODE:
//   - AluSrcA = 0, AluSrcB = 11, AluCtrl = 010 (branch target).
//   - Next state by opcode:
//     - lw 100011 / sw 101011 -> MEMADR
//     - R-type 000000 -> EXECUTE
//     - beq 000100 -> BRANCH
//     - addi 001000 -> ADDIEX
//     - ori 001101 -> ORIEX
//     - j 000010 -> JUMP
//     - other -> FETCH with IllegalOp = 1
// - MEMADR: AluSrcA = 1, AluSrcB = 10, AluCtrl = 010. lw -> MEMRD; sw -> MEMWR.
// - MEMRD: IorD = 1, MemRead = 1. Wait for MemReady, then MEMWB.
// - MEMWB: RegDst = 0, MemToReg = 1, RegWrite = 1; then FETCH.
// - MEMWR: IorD = 1, MemWrite = 1. Wait for MemReady, then FETCH.
// - EXECUTE: AluSrcA = 1, AluSrcB = 00. Funct decode:
//   - 100000 -> 010
//   - 100010 -> 110
//   - 100100 -> 000
//   - 100101 -> 001
//   - 100110 -> 011
//   - 101010 -> 111
//   - Known funct -> ALUWB. Unknown -> FETCH with IllegalOp = 1 and no register write.
// - ALUWB: RegDst = 1, MemToReg = 0, RegWrite = 1; then FETCH.
// - BRANCH: AluSrcA = 1, AluSrcB = 00, AluCtrl = 110, PcSrc = 01, Branch = 1. PcEn = Zero; then FETCH.
// - ADDIEX: AluSrcA = 1, AluSrcB = 10, AluCtrl = 010 -> IMMWB.
// - ORIEX: AluSrcA = 1, AluSrcB = 10, AluCtrl = 001 -> IMMWB.
// - IMMWB: RegDst = 0, MemToReg = 0, RegWrite = 1; then FETCH.
// - JUMP: PcSrc = 10, PcWrite = 1; then FETCH.
// - Latency with MemReady held at 1 (cycles): R / addi / ori / sw = 4, lw = 5, beq / j = 3.
//   - Each MemReady = 0 cycle adds 1.
// - Invariants:
//   - MemRead and MemWrite are never both 1.
//   - RegWrite and MemWrite are never both 1.
//   - At most one PC update per instruction.
// STRUCTURE
// - Package mips_pkg holds: state enum, opcode and funct localparams, AluCtrl encodings (shared with the ALU).
// - Sub-module alu_decoder (combinational): AluOp[1:0] + Funct -> AluCtrl, plus a funct-valid flag.
// - Remainder: state register plus next-state/output always_comb blocks.
// TESTING
// - add: Opcode 000000, Funct 100000, MemReady = 1.
//   -> States FETCH, DECODE, EXECUTE (AluCtrl = 010), ALUWB (RegWrite = 1, RegDst = 1); 4 cycles.
// - lw: Opcode 100011, MemReady low 2 cycles in MEMRD.
//   -> MEMRD held 3 cycles with IorD = 1; MEMWB MemToReg = 1; total 7 cycles.
// - beq: Opcode 000100.
//   -> Zero = 1 gives PcEn = 1, PcSrc = 01, AluCtrl = 110 in BRANCH.
//   -> Zero = 0 gives PcEn = 0; 3 cycles either way.
// - Illegal: Opcode 111111 gives IllegalOp pulse in DECODE and return to FETCH.
//   -> Funct 000001 gives IllegalOp in EXECUTE and RegWrite never asserted.
// - Reset: Rst_n low during MEMWR with MemWrite = 1.
//   -> Same cycle: MemWrite = 0 and State = FETCH; after release, a normal fetch.
// - Sweep all six funct codes and ori.
//   -> AluCtrl = 010, 110, 000, 001, 011, 111 and 001 respectively.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// instruction field codes and ALU control encodings used by the ALU as well.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ORIEX   = 4'd10,
        IMMWB   = 4'd11,
        JUMP    = 4'd12
    } state_e;

    // Operation class handed to the ALU decoder; FUNCT defers to the R-type funct field.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_ORI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, enables,
// selects and ALU control out. The controller is the master end.
interface multicycle_ctrl_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PcEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IrWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] PcSrc;
    logic [2:0] AluCtrl;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Opcode, Funct, Zero, MemReady,
        output PcEn, IorD, MemRead, MemWrite, IrWrite, RegDst, MemToReg, RegWrite,
               AluSrcA, AluSrcB, PcSrc, AluCtrl, IllegalOp, State
    );

    modport slave (
        output Opcode, Funct, Zero, MemReady,
        input  PcEn, IorD, MemRead, MemWrite, IrWrite, RegDst, MemToReg, RegWrite,
               AluSrcA, AluSrcB, PcSrc, AluCtrl, IllegalOp, State
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's operation class plus the R-type funct field onto the
// ALU control code; funct_valid_o flags an unrecognised funct.
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_e     alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_ctrl_o    = ALU_ADD;
        funct_valid_o = 1'b1;
        case (alu_op_i)
            ALUOP_ADD: alu_ctrl_o = ALU_ADD;
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_OR:  alu_ctrl_o = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_XOR:  alu_ctrl_o = ALU_XOR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_valid_o = 1'b0;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter state_e RESET_STATE = FETCH
) (
    input  logic Clk,
    input  logic Rst_n,
    multicycle_ctrl_if.master bus
);

    state_e     state_q, state_d;
    aluop_e     alu_op;
    logic [2:0] alu_ctrl;
    logic       funct_valid;
    logic       pc_write, branch;
    logic       ior_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (bus.Funct),
        .alu_ctrl_o    (alu_ctrl),
        .funct_valid_o (funct_valid)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (bus.MemReady) state_d = DECODE;
            DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_ORI:       state_d = ORIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (bus.MemReady) state_d = MEMWB;
            MEMWR:   if (bus.MemReady) state_d = FETCH;
            EXECUTE: state_d = funct_valid ? ALUWB : FETCH;
            ADDIEX, ORIEX: state_d = IMMWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !opcode_legal(bus.Opcode);
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_OR;
            end
            MEMRD: begin
                ior_d    = 1'b1;
                mem_read = 1'b1;
            end
            MEMWR: begin
                ior_d     = 1'b1;
                mem_write = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                illegal_op = !funct_valid;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            IMMWB:  reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Reset forces every control quiet at once, before the next clock edge.
        if (!Rst_n) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            ior_d      = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            alu_op     = ALUOP_ADD;
            illegal_op = 1'b0;
        end
    end

    assign bus.PcEn      = pc_write | (branch & bus.Zero);
    assign bus.IorD      = ior_d;
    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.IrWrite   = ir_write;
    assign bus.RegDst    = reg_dst;
    assign bus.MemToReg  = mem_to_reg;
    assign bus.RegWrite  = reg_write;
    assign bus.AluSrcA   = alu_src_a;
    assign bus.AluSrcB   = alu_src_b;
    assign bus.PcSrc     = pc_src;
    assign bus.AluCtrl   = alu_ctrl;
    assign bus.IllegalOp = illegal_op;
    assign bus.State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares state and the full control vector against hand values.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    logic Clk;
    logic Rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(.RESET_STATE(FETCH)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {PcEn,IorD,MemRead,MemWrite,IrWrite, RegDst,MemToReg,RegWrite, AluSrcA,AluSrcB,PcSrc,AluCtrl,IllegalOp}
    localparam logic [16:0] C_RST   = 17'b00000_000_0_00_00_010_0;
    localparam logic [16:0] C_FRDY  = 17'b10101_000_0_01_00_010_0;
    localparam logic [16:0] C_FWAIT = 17'b00100_000_0_01_00_010_0;
    localparam logic [16:0] C_DEC   = 17'b00000_000_0_11_00_010_0;
    localparam logic [16:0] C_DECIL = 17'b00000_000_0_11_00_010_1;
    localparam logic [16:0] C_MADR  = 17'b00000_000_1_10_00_010_0;
    localparam logic [16:0] C_MRD   = 17'b01100_000_0_00_00_010_0;
    localparam logic [16:0] C_MWB   = 17'b00000_011_0_00_00_010_0;
    localparam logic [16:0] C_MWR   = 17'b01010_000_0_00_00_010_0;
    localparam logic [16:0] C_AWB   = 17'b00000_101_0_00_00_010_0;
    localparam logic [16:0] C_BRT   = 17'b10000_000_1_00_01_110_0;
    localparam logic [16:0] C_BRN   = 17'b00000_000_1_00_01_110_0;
    localparam logic [16:0] C_ADDI  = 17'b00000_000_1_10_00_010_0;
    localparam logic [16:0] C_ORI   = 17'b00000_000_1_10_00_001_0;
    localparam logic [16:0] C_IWB   = 17'b00000_001_0_00_00_010_0;
    localparam logic [16:0] C_JMP   = 17'b10000_000_0_00_10_010_0;
    localparam logic [16:0] C_EXIL  = 17'b00000_000_1_00_00_010_1;

    logic [5:0] fn_tab [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
    logic [2:0] ac_tab [5] = '{3'b110, 3'b000, 3'b001, 3'b011, 3'b111};

    function automatic logic [16:0] c_ex(input logic [2:0] ac);
        return {5'b00000, 3'b000, 1'b1, 2'b00, 2'b00, ac, 1'b0};
    endfunction

    function automatic logic [16:0] ctl_now();
        return {bus_if.PcEn, bus_if.IorD, bus_if.MemRead, bus_if.MemWrite, bus_if.IrWrite,
                bus_if.RegDst, bus_if.MemToReg, bus_if.RegWrite, bus_if.AluSrcA, bus_if.AluSrcB,
                bus_if.PcSrc, bus_if.AluCtrl, bus_if.IllegalOp};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Drive status inputs, check state and controls, then advance one clock.
    task automatic cyc(input string tag, input logic mr, input logic z,
                       input state_e st, input logic [16:0] ctl);
        bus_if.MemReady = mr;
        bus_if.Zero     = z;
        #1;
        check({tag, ".state"}, {13'd0, bus_if.State}, {13'd0, st});
        check({tag, ".ctl"}, ctl_now(), ctl);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n           = 1'b0;
        bus_if.Opcode   = OP_RTYPE;
        bus_if.Funct    = FN_ADD;
        bus_if.Zero     = 1'b0;
        bus_if.MemReady = 1'b1;
        #3;
        check("reset.state", {13'd0, bus_if.State}, {13'd0, FETCH});
        check("reset.ctl", ctl_now(), C_RST);
        #14;
        Rst_n = 1'b1;

        // add
        cyc("add.fetch", 1, 0, FETCH, C_FRDY);
        cyc("add.dec",   1, 0, DECODE, C_DEC);
        cyc("add.ex",    1, 0, EXECUTE, c_ex(3'b010));
        cyc("add.wb",    1, 0, ALUWB, C_AWB);

        // lw with a fetch stall and two MEMRD stalls
        bus_if.Opcode = OP_LW;
        cyc("lw.fwait",  0, 0, FETCH, C_FWAIT);
        cyc("lw.fetch",  1, 0, FETCH, C_FRDY);
        cyc("lw.dec",    1, 0, DECODE, C_DEC);
        cyc("lw.adr",    1, 0, MEMADR, C_MADR);
        cyc("lw.rd0",    0, 0, MEMRD, C_MRD);
        cyc("lw.rd1",    0, 0, MEMRD, C_MRD);
        cyc("lw.rd2",    1, 0, MEMRD, C_MRD);
        cyc("lw.wb",     1, 0, MEMWB, C_MWB);

        // sw
        bus_if.Opcode = OP_SW;
        cyc("sw.fetch",  1, 0, FETCH, C_FRDY);
        cyc("sw.dec",    1, 0, DECODE, C_DEC);
        cyc("sw.adr",    1, 0, MEMADR, C_MADR);
        cyc("sw.wr",     1, 0, MEMWR, C_MWR);

        // beq taken / not taken
        bus_if.Opcode = OP_BEQ;
        cyc("beqT.fetch", 1, 0, FETCH, C_FRDY);
        cyc("beqT.dec",   1, 0, DECODE, C_DEC);
        cyc("beqT.br",    1, 1, BRANCH, C_BRT);
        cyc("beqN.fetch", 1, 0, FETCH, C_FRDY);
        cyc("beqN.dec",   1, 0, DECODE, C_DEC);
        cyc("beqN.br",    1, 0, BRANCH, C_BRN);

        // j
        bus_if.Opcode = OP_J;
        cyc("j.fetch",   1, 0, FETCH, C_FRDY);
        cyc("j.dec",     1, 0, DECODE, C_DEC);
        cyc("j.jump",    1, 0, JUMP, C_JMP);

        // addi, ori
        bus_if.Opcode = OP_ADDI;
        cyc("addi.fetch", 1, 0, FETCH, C_FRDY);
        cyc("addi.dec",   1, 0, DECODE, C_DEC);
        cyc("addi.ex",    1, 0, ADDIEX, C_ADDI);
        cyc("addi.wb",    1, 0, IMMWB, C_IWB);
        bus_if.Opcode = OP_ORI;
        cyc("ori.fetch",  1, 0, FETCH, C_FRDY);
        cyc("ori.dec",    1, 0, DECODE, C_DEC);
        cyc("ori.ex",     1, 0, ORIEX, C_ORI);
        cyc("ori.wb",     1, 0, IMMWB, C_IWB);

        // illegal opcode, then illegal funct
        bus_if.Opcode = 6'b111111;
        cyc("illop.fetch", 1, 0, FETCH, C_FRDY);
        cyc("illop.dec",   1, 0, DECODE, C_DECIL);
        bus_if.Opcode = OP_RTYPE;
        bus_if.Funct  = 6'b000001;
        cyc("illfn.fetch", 1, 0, FETCH, C_FRDY);
        cyc("illfn.dec",   1, 0, DECODE, C_DEC);
        cyc("illfn.ex",    1, 0, EXECUTE, C_EXIL);
        cyc("illfn.back",  1, 0, FETCH, C_FRDY);
        cyc("illfn.dec2",  1, 0, DECODE, C_DEC);

        // remaining funct codes; the pending decode above leads into the first
        bus_if.Funct = fn_tab[0];
        cyc("sub.ex",  1, 0, EXECUTE, c_ex(ac_tab[0]));
        cyc("sub.wb",  1, 0, ALUWB, C_AWB);
        for (int i = 1; i < 5; i++) begin
            bus_if.Funct = fn_tab[i];
            cyc("fn.fetch", 1, 0, FETCH, C_FRDY);
            cyc("fn.dec",   1, 0, DECODE, C_DEC);
            cyc("fn.ex",    1, 0, EXECUTE, c_ex(ac_tab[i]));
            cyc("fn.wb",    1, 0, ALUWB, C_AWB);
        end

        // reset asserted mid-store
        bus_if.Opcode = OP_SW;
        cyc("rsw.fetch", 1, 0, FETCH, C_FRDY);
        cyc("rsw.dec",   1, 0, DECODE, C_DEC);
        cyc("rsw.adr",   1, 0, MEMADR, C_MADR);
        bus_if.MemReady = 1'b0;
        #1;
        check("rsw.wr.ctl", ctl_now(), C_MWR);
        #1;
        Rst_n = 1'b0;
        #1;
        check("rsw.rst.state", {13'd0, bus_if.State}, {13'd0, FETCH});
        check("rsw.rst.ctl", ctl_now(), C_RST);
        @(posedge Clk);
        #1;
        Rst_n         = 1'b1;
        bus_if.Opcode = OP_RTYPE;
        bus_if.Funct  = FN_ADD;
        cyc("post.fetch", 1, 0, FETCH, C_FRDY);
        cyc("post.dec",   1, 0, DECODE, C_DEC);
        cyc("post.ex",    1, 0, EXECUTE, c_ex(3'b010));
        cyc("post.wb",    1, 0, ALUWB, C_AWB);
        cyc("post.next",  0, 0, FETCH, C_FWAIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
